// File: rtl/fifo_fc_param.sv
// Parametrised FIFO with occupancy-counter full/empty, hysteresis almost_full flow control
// and a sticky, typed, clearable error state.
module fifo_fc_param #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
  input  logic          push,
  input  logic          pop,
  input  logic [AW:0]   umbral_af,
  input  logic [AW:0]   umbral_ae,
  input  logic          err_clr,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic [AW:0]   count,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          almost_full,
  output logic          error,
  output logic [1:0]    err_code
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, PAUSE, ERROR} state_t;

  state_t        state;
  state_t        fc_next;
  state_t        clr_state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          in_op;
  logic          pop_acc;
  logic          push_acc;
  logic          overflow;
  logic          underflow;
  logic [CW-1:0] count_next;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));

  // Acceptance, error detection and flow-control next state from the post-update occupancy
  always_comb begin
    in_op      = 1'b0;
    pop_acc    = 1'b0;
    push_acc   = 1'b0;
    overflow   = 1'b0;
    underflow  = 1'b0;
    count_next = count;
    fc_next    = state;
    clr_state  = ACTIVE;

    in_op      = (state != ERROR);
    pop_acc    = in_op && pop && !fifo_empty;
    push_acc   = in_op && push && (!fifo_full || pop_acc);
    overflow   = in_op && push && !push_acc;
    underflow  = in_op && pop && !pop_acc;
    count_next = count + CW'(push_acc) - CW'(pop_acc);

    case (state)
      IDLE:    if (count_next != '0) fc_next = ACTIVE;
      ACTIVE:  if (count_next == '0) fc_next = IDLE;
               else if (count_next >= umbral_af) fc_next = PAUSE;
      PAUSE:   if (count_next == '0) fc_next = IDLE;
               else if (count_next <= umbral_ae) fc_next = ACTIVE;
      default: fc_next = state;
    endcase

    // State rebuilt from the frozen occupancy when leaving ERROR
    if (count == '0)
      clr_state = IDLE;
    else if (count >= umbral_af)
      clr_state = PAUSE;
    else
      clr_state = ACTIVE;
  end

  // Storage array, no reset: contents are meaningless until written
  always_ff @(posedge clk) begin
    if (reset && push_acc)
      mem[wr_ptr] <= data_in;
  end

  // Pointers, occupancy, read port, flow-control FSM and error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      almost_full <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      valid_out <= 1'b0;
      if (state == ERROR) begin
        if (err_clr) begin
          error       <= 1'b0;
          err_code    <= 2'b00;
          state       <= clr_state;
          almost_full <= (clr_state == PAUSE);
        end
      end else begin
        if (pop_acc) begin
          data_out  <= mem[rd_ptr];
          valid_out <= 1'b1;
          rd_ptr    <= rd_ptr + AW'(1);
        end
        if (push_acc)
          wr_ptr <= wr_ptr + AW'(1);
        count <= count_next;
        // Error wins over the flow-control transition; almost_full holds its value
        if (overflow || underflow) begin
          error    <= 1'b1;
          err_code <= {underflow, overflow};
          state    <= ERROR;
        end else begin
          state       <= fc_next;
          almost_full <= (fc_next == PAUSE);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_fc_param.sv
// Self-checking bench for fifo_fc_param: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fifo_fc_param;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          push;
  logic          pop;
  logic [AW:0]   umbral_af;
  logic [AW:0]   umbral_ae;
  logic          err_clr;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          almost_full;
  logic          error;
  logic [1:0]    err_code;

  fifo_fc_param #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .push        (push),
    .pop         (pop),
    .umbral_af   (umbral_af),
    .umbral_ae   (umbral_ae),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .count       (count),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .error       (error),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: plain queue plus flags
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_af;
  logic       m_err;
  logic [1:0] m_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int  n;
    bit  pok;
    bit  wok;
    if (!reset) begin
      mq.delete();
      m_dout = 8'h00; m_valid = 1'b0; m_af = 1'b0; m_err = 1'b0; m_code = 2'b00;
    end else if (m_err) begin
      m_valid = 1'b0;
      if (err_clr) begin
        m_err  = 1'b0;
        m_code = 2'b00;
        m_af   = (mq.size() != 0) && (mq.size() >= int'(umbral_af));
      end
    end else begin
      n   = mq.size();
      pok = pop && (n > 0);
      wok = push && ((n < int'(DEPTH)) || pok);
      m_valid = pok;
      if (pok) m_dout = mq.pop_front();
      if (wok) mq.push_back(data_in);
      if ((push && !wok) || (pop && !pok)) begin
        m_err  = 1'b1;
        m_code = {pop && !pok, push && !wok};
      end else begin
        n = mq.size();
        if (n == 0) m_af = 1'b0;
        else if (m_af && n <= int'(umbral_ae)) m_af = 1'b0;
        else if (!m_af && n >= int'(umbral_af)) m_af = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("count",       32'(count),       32'(mq.size()));
    chk("fifo_empty",  32'(fifo_empty),  32'(mq.size() == 0));
    chk("fifo_full",   32'(fifo_full),   32'(mq.size() == int'(DEPTH)));
    chk("almost_full", 32'(almost_full), 32'(m_af));
    chk("error",       32'(error),       32'(m_err));
    chk("err_code",    32'(err_code),    32'(m_code));
    chk("valid_out",   32'(valid_out),   32'(m_valid));
    chk("data_out",    32'(data_out),    32'(m_dout));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic p, input logic q, input logic c, input logic [7:0] d);
    reset = r; push = p; pop = q; err_clr = c; data_in = d;
  endtask

  typedef struct {
    logic       rst;
    logic       psh;
    logic       pp;
    logic       clr;
    logic [7:0] din;
    int         cnt;
    logic       vld;
    logic [7:0] dout;
    logic       af;
    logic       err;
    logic [1:0] code;
  } vec_t;

  vec_t vt[13];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    umbral_af = 4'd6;
    umbral_ae = 4'd2;

    //          rst  push pop  clr  din    cnt vld  dout   af   err  code
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA1, 1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hB2, 2, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 3, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b1, 8'hA1, 1'b0, 1'b0, 2'b00};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b1, 8'hB2, 1'b0, 1'b0, 2'b00};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'hC3, 1'b0, 1'b0, 2'b00};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'hC3, 1'b0, 1'b0, 2'b00};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 8'hC3, 1'b0, 1'b1, 2'b10};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'hC3, 1'b0, 1'b0, 2'b00};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 1, 1'b0, 8'hC3, 1'b0, 1'b1, 2'b10};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 8'hC3, 1'b0, 1'b0, 2'b00};
    vt[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h5A, 1'b0, 1'b0, 2'b00};

    tick();
    tick();

    // T1 / T4 directed vectors
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].rst, vt[i].psh, vt[i].pp, vt[i].clr, vt[i].din);
      tick();
      chk($sformatf("vec%0d.count", i),    32'(count),       32'(vt[i].cnt));
      chk($sformatf("vec%0d.valid", i),    32'(valid_out),   32'(vt[i].vld));
      chk($sformatf("vec%0d.dout", i),     32'(data_out),    32'(vt[i].dout));
      chk($sformatf("vec%0d.af", i),       32'(almost_full), 32'(vt[i].af));
      chk($sformatf("vec%0d.err", i),      32'(error),       32'(vt[i].err));
      chk($sformatf("vec%0d.code", i),     32'(err_code),    32'(vt[i].code));
    end

    // T2: almost_full hysteresis
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h10 + i)); tick();
      chk("t2.af_fill", 32'(almost_full), 32'(i == 5));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); tick();
    end
    chk("t2.af_at3", 32'(almost_full), 32'(1));
    tick();
    chk("t2.af_at2", 32'(almost_full), 32'(0));
    chk("t2.count", 32'(count), 32'(2));

    // T3: overflow at full, frozen state, clear into PAUSE, drain in order
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h20 + i)); tick();
    end
    chk("t3.full", 32'(fifo_full), 32'(1));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF); tick();
    chk("t3.err", 32'(error), 32'(1));
    chk("t3.code", 32'(err_code), 32'(2'b01));
    chk("t3.count", 32'(count), 32'(8));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); tick();
    chk("t3.pop_ignored", 32'(count), 32'(8));
    chk("t3.no_valid", 32'(valid_out), 32'(0));
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00); tick();
    chk("t3.cleared", 32'(error), 32'(0));
    chk("t3.pause_af", 32'(almost_full), 32'(1));
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); tick();
    end
    chk("t3.empty", 32'(fifo_empty), 32'(1));

    // T5: push+pop at full across pointer wrap
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h30 + i)); tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 8'(8'h40 + i)); tick();
      chk("t5.count", 32'(count), 32'(8));
      chk("t5.noerr", 32'(error), 32'(0));
    end

    // T6: reset mid-operation discards contents
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h60 + i)); tick();
    end
    chk("t6.count5", 32'(count), 32'(5));
    chk("t6.af0", 32'(almost_full), 32'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    chk("t6.rst_count", 32'(count), 32'(0));
    chk("t6.rst_dout", 32'(data_out), 32'(0));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); tick();
    chk("t6.udf_err", 32'(error), 32'(1));
    chk("t6.udf_code", 32'(err_code), 32'(2'b10));

    // Randomized traffic against the reference model
    for (int seg = 0; seg < 6; seg++) begin
      int bias;
      umbral_af = 4'($urandom_range(2, 9));
      umbral_ae = 4'($urandom_range(0, int'(umbral_af) - 1));
      bias = (seg % 2 == 0) ? 65 : 35;
      for (int c = 0; c < 500; c++) begin
        drive(($urandom_range(0, 299) != 0),
              ($urandom_range(0, 99) < bias),
              ($urandom_range(0, 99) < (100 - bias)),
              ($urandom_range(0, 7) == 0),
              8'($urandom));
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
